// File: rtl/button_pulse_bank.sv
// Multi-channel push-button conditioner: sync, debounce, press pulse, auto-repeat.
// Define PB_RELEASE_PULSE_EN to add the btn_release one-cycle pulse output.
module button_pulse_bank #(
    parameter int N_CH          = 4,
    parameter int DB_CYCLES     = 16,
    parameter int HOLD_CYCLES   = 1000,
    parameter int REPEAT_CYCLES = 200,
    parameter int CNT_W         = 20
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_raw,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_pulse,
    output logic [N_CH-1:0] btn_hold
`ifdef PB_RELEASE_PULSE_EN
    ,
    output logic [N_CH-1:0] btn_release
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESSED,
        S_HOLD
    } state_e;

    localparam bit             REP_EN   = (REPEAT_CYCLES > 0);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] DB_MAX   = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_MAX  = CNT_W'(REP_EN ? REPEAT_CYCLES - 1 : 0);

    logic [N_CH-1:0]  sync1_q, sync1_d;
    logic [N_CH-1:0]  sync2_q, sync2_d;
    logic [N_CH-1:0]  level_q, level_d;
    logic [N_CH-1:0]  lvl_prev_q, lvl_prev_d;
    logic [N_CH-1:0]  pulse_q, pulse_d;
    logic [N_CH-1:0]  rep_tick;
    logic [CNT_W-1:0] db_cnt_q [N_CH];
    logic [CNT_W-1:0] db_cnt_d [N_CH];
    logic [CNT_W-1:0] hold_cnt_q [N_CH];
    logic [CNT_W-1:0] hold_cnt_d [N_CH];
    logic [CNT_W-1:0] rep_cnt_q [N_CH];
    logic [CNT_W-1:0] rep_cnt_d [N_CH];
    state_e           state_q [N_CH];
    state_e           state_d [N_CH];

    always_comb begin
        sync1_d    = btn_raw;
        sync2_d    = sync1_q;
        lvl_prev_d = level_q;
        level_d    = level_q;
        rep_tick   = '0;
        for (int i = 0; i < N_CH; i++) begin
            db_cnt_d[i]   = db_cnt_q[i];
            hold_cnt_d[i] = hold_cnt_q[i];
            rep_cnt_d[i]  = rep_cnt_q[i];
            state_d[i]    = state_q[i];

            // Level flips only after DB_CYCLES consecutive disagreeing samples.
            if (sync2_q[i] != level_q[i]) begin
                if (db_cnt_q[i] == DB_MAX) begin
                    level_d[i]  = ~level_q[i];
                    db_cnt_d[i] = '0;
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + ONE;
                end
            end else begin
                db_cnt_d[i] = '0;
            end

            case (state_q[i])
                S_IDLE: begin
                    hold_cnt_d[i] = '0;
                    rep_cnt_d[i]  = '0;
                    if (level_q[i]) state_d[i] = S_PRESSED;
                end
                S_PRESSED: begin
                    if (!level_q[i]) begin
                        state_d[i]    = S_IDLE;
                        hold_cnt_d[i] = '0;
                        rep_cnt_d[i]  = '0;
                    end else if (hold_cnt_q[i] == HOLD_MAX) begin
                        state_d[i]   = S_HOLD;
                        rep_cnt_d[i] = '0;
                        rep_tick[i]  = REP_EN;
                    end else begin
                        hold_cnt_d[i] = hold_cnt_q[i] + ONE;
                    end
                end
                S_HOLD: begin
                    // A tick landing on the release cycle is dropped here.
                    if (!level_q[i]) begin
                        state_d[i]    = S_IDLE;
                        hold_cnt_d[i] = '0;
                        rep_cnt_d[i]  = '0;
                    end else if (REP_EN) begin
                        if (rep_cnt_q[i] == REP_MAX) begin
                            rep_cnt_d[i] = '0;
                            rep_tick[i]  = 1'b1;
                        end else begin
                            rep_cnt_d[i] = rep_cnt_q[i] + ONE;
                        end
                    end
                end
                default: begin
                    state_d[i]    = S_IDLE;
                    hold_cnt_d[i] = '0;
                    rep_cnt_d[i]  = '0;
                end
            endcase
        end
        pulse_d = (level_q & ~lvl_prev_q) | rep_tick;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            level_q    <= '0;
            lvl_prev_q <= '0;
            pulse_q    <= '0;
            for (int i = 0; i < N_CH; i++) begin
                db_cnt_q[i]   <= '0;
                hold_cnt_q[i] <= '0;
                rep_cnt_q[i]  <= '0;
                state_q[i]    <= S_IDLE;
            end
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            level_q    <= level_d;
            lvl_prev_q <= lvl_prev_d;
            pulse_q    <= pulse_d;
            for (int i = 0; i < N_CH; i++) begin
                db_cnt_q[i]   <= db_cnt_d[i];
                hold_cnt_q[i] <= hold_cnt_d[i];
                rep_cnt_q[i]  <= rep_cnt_d[i];
                state_q[i]    <= state_d[i];
            end
        end
    end

    always_comb begin
        btn_level = level_q;
        btn_pulse = pulse_q;
        for (int i = 0; i < N_CH; i++) begin
            btn_hold[i] = (state_q[i] == S_HOLD);
        end
    end

`ifdef PB_RELEASE_PULSE_EN
    logic [N_CH-1:0] release_q, release_d;

    always_comb begin
        release_d = ~level_q & lvl_prev_q;
    end

    always_ff @(posedge clk) begin
        if (rst) release_q <= '0;
        else     release_q <= release_d;
    end

    assign btn_release = release_q;
`else
    // No release detection in this build.
`endif

endmodule

// File: tb/tb_button_pulse_bank.sv
// Directed bench for button_pulse_bank (N_CH=4, DB=4, HOLD=20, REPEAT=8).
module tb_button_pulse_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn_raw = '0;
    logic [3:0] btn_level;
    logic [3:0] btn_pulse;
    logic [3:0] btn_hold;
`ifdef PB_RELEASE_PULSE_EN
    logic [3:0] btn_release;
`endif

    int checks = 0;
    int errors = 0;

    button_pulse_bank #(
        .N_CH(4),
        .DB_CYCLES(4),
        .HOLD_CYCLES(20),
        .REPEAT_CYCLES(8),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_raw(btn_raw),
        .btn_level(btn_level),
        .btn_pulse(btn_pulse),
        .btn_hold(btn_hold)
`ifdef PB_RELEASE_PULSE_EN
        ,
        .btn_release(btn_release)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] raw;
        logic [3:0] lvl;
        logic [3:0] pls;
        logic [3:0] hld;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [3:0] raw,
                       input logic [3:0] l, input logic [3:0] p,
                       input logic [3:0] h, input int n);
        vec_t v;
        v.rst = r;
        v.raw = raw;
        v.lvl = l;
        v.pls = p;
        v.hld = h;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int step,
                         input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d got lvl/pls/hld=%h want %h",
                     name, step, act, exp);
        end
    endtask

    task automatic check_rel(input string name, input int step,
                             input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d got release=%h want %h",
                     name, step, act, exp);
        end
    endtask

    initial begin
        logic [3:0] el, ep, eh, er;

        // reset with all buttons held, then release of all
        add(1, 4'hF, 4'h0, 4'h0, 4'h0, 3);
        add(0, 4'hF, 4'h0, 4'h0, 4'h0, 5);
        add(0, 4'hF, 4'hF, 4'h0, 4'h0, 1);
        add(0, 4'hF, 4'hF, 4'hF, 4'h0, 1);
        add(0, 4'hF, 4'hF, 4'h0, 4'h0, 1);
        add(0, 4'h0, 4'hF, 4'h0, 4'h0, 5);
        add(0, 4'h0, 4'h0, 4'h0, 4'h0, 4);
        // 3-cycle glitch on ch0 is rejected
        add(0, 4'h1, 4'h0, 4'h0, 4'h0, 3);
        add(0, 4'h0, 4'h0, 4'h0, 4'h0, 6);
        // exactly DB_CYCLES on ch1 is accepted
        add(0, 4'h2, 4'h0, 4'h0, 4'h0, 4);
        add(0, 4'h0, 4'h0, 4'h0, 4'h0, 1);
        add(0, 4'h0, 4'h2, 4'h0, 4'h0, 1);
        add(0, 4'h0, 4'h2, 4'h2, 4'h0, 1);
        add(0, 4'h0, 4'h2, 4'h0, 4'h0, 2);
        add(0, 4'h0, 4'h0, 4'h0, 4'h0, 3);
        // clean 10-cycle press on ch1
        add(0, 4'h2, 4'h0, 4'h0, 4'h0, 5);
        add(0, 4'h2, 4'h2, 4'h0, 4'h0, 1);
        add(0, 4'h2, 4'h2, 4'h2, 4'h0, 1);
        add(0, 4'h2, 4'h2, 4'h0, 4'h0, 3);
        add(0, 4'h0, 4'h2, 4'h0, 4'h0, 5);
        add(0, 4'h0, 4'h0, 4'h0, 4'h0, 3);
        // ch0 press alongside a ch3 glitch
        add(0, 4'h9, 4'h0, 4'h0, 4'h0, 2);
        add(0, 4'h1, 4'h0, 4'h0, 4'h0, 3);
        add(0, 4'h1, 4'h1, 4'h0, 4'h0, 1);
        add(0, 4'h1, 4'h1, 4'h1, 4'h0, 1);
        add(0, 4'h0, 4'h1, 4'h0, 4'h0, 5);
        add(0, 4'h0, 4'h0, 4'h0, 4'h0, 3);

        foreach (vecs[i]) begin
            rst     = vecs[i].rst;
            btn_raw = vecs[i].raw;
            tick();
            check("table", i, {btn_level, btn_pulse, btn_hold},
                  {vecs[i].lvl, vecs[i].pls, vecs[i].hld});
        end

        // long hold on ch2: 60 cycles high
        for (int n = 1; n <= 72; n++) begin
            btn_raw = (n <= 60) ? 4'h4 : 4'h0;
            tick();
            el = (n >= 6 && n <= 65) ? 4'h4 : 4'h0;
            ep = (n == 7 || (n >= 27 && n <= 59 && (n - 27) % 8 == 0))
                 ? 4'h4 : 4'h0;
            eh = (n >= 27 && n <= 66) ? 4'h4 : 4'h0;
            check("long_hold", n, {btn_level, btn_pulse, btn_hold},
                  {el, ep, eh});
`ifdef PB_RELEASE_PULSE_EN
            er = (n == 67) ? 4'h4 : 4'h0;
            check_rel("hold_release", n, btn_release, er);
`endif
        end

        // reset while ch2 is in HOLD, button kept down
        btn_raw = 4'h4;
        for (int n = 1; n <= 30; n++) tick();
        check("pre_abort", 30, {btn_level, btn_pulse, btn_hold},
              {4'h4, 4'h0, 4'h4});
        rst = 1'b1;
        tick();
        check("rst_abort", 0, {btn_level, btn_pulse, btn_hold}, 12'h000);
        rst = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            tick();
            el = (n >= 6) ? 4'h4 : 4'h0;
            ep = (n == 7 || n == 27) ? 4'h4 : 4'h0;
            eh = (n >= 27) ? 4'h4 : 4'h0;
            check("after_abort", n, {btn_level, btn_pulse, btn_hold},
                  {el, ep, eh});
        end
        btn_raw = 4'h0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // short press and release on ch3
        for (int n = 1; n <= 20; n++) begin
            btn_raw = (n <= 10) ? 4'h8 : 4'h0;
            tick();
            el = (n >= 6 && n <= 15) ? 4'h8 : 4'h0;
            ep = (n == 7) ? 4'h8 : 4'h0;
            check("ch3_press", n, {btn_level, btn_pulse, btn_hold},
                  {el, ep, 4'h0});
`ifdef PB_RELEASE_PULSE_EN
            er = (n == 17) ? 4'h8 : 4'h0;
            check_rel("ch3_release", n, btn_release, er);
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_pulse_bank.md
Name: button_pulse_bank

Overview:
- Multi-channel push-button conditioner: 2-flop synchroniser, counter-based debounce, registered single-cycle press pulse, and long-press auto-repeat per channel.
- Parametrised successor to the single-channel rising-edge pulser.
- Sits between board push-buttons and game-control logic (jump, move, menu).
- Emits one `btn_pulse` per press, plus periodic repeat pulses while a button is held.

Parameters:
- N_CH, 4: number of independent button channels.
- DB_CYCLES, 16: debounce time; the synchronised input must differ from the debounced level for this many consecutive cycles before the level flips. Legal range is 1 or more.
- HOLD_CYCLES, 1000: cycles the debounced level must stay high before hold/repeat engages. Legal range is 2 or more.
- REPEAT_CYCLES, 200: auto-repeat period once in hold. A value of 0 disables repeat pulses; `btn_hold` still operates.
- CNT_W, 20: width of the debounce and hold counters. Must hold max(DB_CYCLES, HOLD_CYCLES, REPEAT_CYCLES).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- btn_raw  in  N_CH  asynchronous raw button inputs, active-high.
- btn_level  out  N_CH  debounced level per channel.
- btn_pulse  out  N_CH  one-cycle pulse on press and on each auto-repeat tick.
- btn_hold  out  N_CH  high while the channel is in the hold state.
- btn_release  out  N_CH  one-cycle pulse on debounced release. Present only with PB_RELEASE_PULSE_EN.

Behaviour:
- Single clock domain. `clk` and `rst` are fixed as: one clock; reset is synchronous and active-high.
- Reset, on any `clk` edge with `rst=1`:
  - sync flops, debounce counters, hold counters and repeat counters clear to 0;
  - `btn_level`, `btn_pulse`, `btn_hold` and `btn_release` are 0;
  - a reset mid-press or mid-hold aborts silently, with no pulse.
  - After reset, a button already held must debounce again before it produces a press pulse.
- Synchroniser: `btn_raw` passes through two flops to give `sync[i]`. Latency is 2 cycles.
- Debounce, per channel:
  - If `sync != btn_level`, `db_cnt` increments.
  - When `db_cnt == DB_CYCLES-1` and sync still differs, `btn_level` toggles and `db_cnt` clears.
  - If `sync == btn_level`, `db_cnt` clears. Any glitch shorter than DB_CYCLES is fully rejected.
  - A raw change stable from edge k makes `btn_level` change at edge k+2+DB_CYCLES.
- Press pulse: `btn_pulse` is registered as `btn_level & ~level_d` (`level_d` is the previous `btn_level`). It is high for exactly 1 cycle, at edge k+3+DB_CYCLES.
- Hold/repeat per channel, FSM IDLE -> PRESSED -> HOLD:
  - IDLE: `btn_level=0`, counters 0. A rising `btn_level` moves to PRESSED with `hold_cnt=0`.
  - PRESSED: `hold_cnt` increments each cycle `btn_level=1`. When `hold_cnt == HOLD_CYCLES-1`, move to HOLD; `btn_hold` goes 1 next cycle and a repeat pulse is emitted on `btn_pulse` that same cycle if REPEAT_CYCLES>0. `rep_cnt` is set to 0.
  - HOLD: `rep_cnt` increments. At `REPEAT_CYCLES-1` it emits one `btn_pulse` and wraps to 0.
  - Any state: `btn_level` falling returns to IDLE next cycle; `btn_hold` drops to 0 and all counters clear. A repeat tick coinciding with release is suppressed.
- Repeat pulses and press pulse never coincide, because HOLD_CYCLES ≥ 2.
- Channels are fully independent; simultaneous events on different channels are each handled without interaction.
- Counter saturation: `hold_cnt` stops once in HOLD, with no wrap.

Optional Feature:
- Macro: PB_RELEASE_PULSE_EN.
- When defined: `btn_release` port exists. It is registered as `~btn_level & level_d`, giving a one-cycle pulse at edge j+1 when `btn_level` falls at edge j. It asserts whether or not the channel was in HOLD.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan (N_CH=4, DB_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8, CNT_W=8):
- Reset: assert `rst` 3 cycles with `btn_raw=4'b1111` -> all outputs 0 throughout. Release `rst` -> `btn_level[3:0]` rises at edge 6 after release, and `btn_pulse=4'b1111` for 1 cycle at edge 7.
- Glitch: `btn_raw[0]` high for 3 cycles, then low -> `btn_level[0]` and `btn_pulse[0]` stay 0.
- Clean press: `btn_raw[1]` rises at edge k and stays high 10 cycles -> `btn_level[1]=1` at k+6, `btn_pulse[1]=1` only at k+7, `btn_hold[1]=0`.
- Long hold: `btn_raw[2]` high for 60 cycles -> press pulse at k+7; `btn_hold[2]` at k+27 with a pulse there; repeat pulses at k+35, k+43, ...; none after `btn_level` falls; `btn_hold` clears 1 cycle after the fall.
- Reset mid-hold: `rst` for 1 cycle while channel 2 is in HOLD with `btn_raw` still high -> `btn_hold`=0 next cycle, no pulse; press pulse re-occurs 7 cycles after `rst` deasserts (2 sync + 4 debounce + 1 pulse register).
- PB_RELEASE_PULSE_EN: press then release channel 3 -> `btn_release[3]=1` for exactly 1 cycle, the edge after `btn_level[3]` falls. Without the macro, the build has no `btn_release` port.
